// File: rtl/uart_imem_loader.sv
// Boot loader: receives a length-prefixed program image over 8N1 UART and streams it
// into instruction memory one 32-bit word at a time, holding the CPU in reset until done.
module uart_imem_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DEPTH        = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        uart_rx,
  output logic        im_we,
  output logic [31:0] im_addr,
  output logic [31:0] im_wdata,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [16:0]   DEPTH_L = 17'(DEPTH);

  // ---------------- RX front end ----------------
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  rx_state_e       rx_st_q, rx_st_d;
  logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_sh_q, rx_sh_d;
  logic            byte_vld_q, byte_vld_d;
  logic            frame_err_q, frame_err_d;
  logic            rx_s1_q, rx_s2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      rx_st_q     <= RX_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_sh_q     <= '0;
      byte_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_s1_q     <= uart_rx;
      rx_s2_q     <= rx_s1_q;
      rx_st_q     <= rx_st_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_sh_q     <= rx_sh_d;
      byte_vld_q  <= byte_vld_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    rx_st_d     = rx_st_q;
    rx_cnt_d    = rx_cnt_q;
    rx_bit_d    = rx_bit_q;
    rx_sh_d     = rx_sh_q;
    byte_vld_d  = 1'b0;
    frame_err_d = 1'b0;
    unique case (rx_st_q)
      RX_IDLE: begin
        if (!rx_s2_q) begin
          rx_st_d  = RX_START;
          rx_cnt_d = '0;
        end
      end
      RX_START: begin
        // mid-bit re-check of the start bit rejects short glitches
        if (rx_cnt_q == HALF_M1) begin
          rx_cnt_d = '0;
          rx_bit_d = '0;
          rx_st_d  = rx_s2_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == FULL_M1) begin
          rx_cnt_d = '0;
          rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
          rx_bit_d = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_st_d = RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == FULL_M1) begin
          rx_cnt_d    = '0;
          rx_st_d     = RX_IDLE;
          byte_vld_d  = rx_s2_q;
          frame_err_d = !rx_s2_q;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      default: rx_st_d = RX_IDLE;
    endcase
  end

  // ---------------- Image loader ----------------
  typedef enum logic [2:0] {LEN_HI, LEN_LO, DATA, DONE, ERR} ld_state_e;

  ld_state_e   ld_st_q, ld_st_d;
  logic [15:0] len_q, len_d;
  logic [15:0] idx_q, idx_d;
  logic [15:0] idx_nx;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [31:0] asm_q, asm_d;
  logic [31:0] word;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        hold_q, hold_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ld_st_q <= LEN_HI;
      len_q   <= '0;
      idx_q   <= '0;
      bcnt_q  <= '0;
      asm_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      hold_q  <= 1'b1;
    end else begin
      ld_st_q <= ld_st_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      bcnt_q  <= bcnt_d;
      asm_q   <= asm_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    ld_st_d = ld_st_q;
    len_d   = len_q;
    idx_d   = idx_q;
    bcnt_d  = bcnt_q;
    asm_d   = asm_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    done_d  = done_q;
    err_d   = err_q;
    hold_d  = hold_q;
    idx_nx  = idx_q + 16'd1;
    word    = {asm_q[23:0], rx_sh_q};

    if (frame_err_q && ld_st_q != DONE && ld_st_q != ERR) begin
      ld_st_d = ERR;
      err_d   = 1'b1;
    end else if (byte_vld_q) begin
      unique case (ld_st_q)
        LEN_HI: begin
          len_d[15:8] = rx_sh_q;
          ld_st_d     = LEN_LO;
        end
        LEN_LO: begin
          len_d[7:0] = rx_sh_q;
          idx_d      = '0;
          bcnt_d     = '0;
          // empty image: release the CPU straight away
          if ({len_q[15:8], rx_sh_q} == 16'd0) begin
            ld_st_d = DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            ld_st_d = DATA;
          end
        end
        DATA: begin
          asm_d  = word;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            if ({1'b0, idx_q} < DEPTH_L) begin
              we_d    = 1'b1;
              addr_d  = {14'b0, idx_q, 2'b00};
              wdata_d = word;
            end
            idx_d = idx_nx;
            if (idx_nx == len_q) ld_st_d = DONE;
          end
        end
        default: ;
      endcase
    end

    // DONE is entered on the edge that raises the last strobe, so the flags follow a clk later
    if (ld_st_q == DONE) begin
      done_d = 1'b1;
      hold_d = 1'b0;
    end
  end

  assign im_we     = we_q;
  assign im_addr   = addr_q;
  assign im_wdata  = wdata_q;
  assign cpu_hold  = hold_q;
  assign load_done = done_q;
  assign load_err  = err_q;

endmodule
